// File: rtl/ex_operand_stage_if.sv
// ID-stage bundle feeding the ID/EX register: decoded operands, indices and control.
// ID drives through the master modport; the execute operand stage samples through slave.
interface ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              idValid;
  logic [DATA_W-1:0] idReadData1;
  logic [DATA_W-1:0] idReadData2;
  logic [DATA_W-1:0] idSignExt;
  logic [REG_W-1:0]  idRs;
  logic [REG_W-1:0]  idRt;
  logic [REG_W-1:0]  idRd;
  logic [5:0]        idFunct;
  logic [1:0]        idAluOp;
  logic              idAluSrc;
  logic              idRegDst;
  logic              idRegWrite;
  logic              idMemRead;
  logic              idMemWrite;
  logic              idMemToReg;
  logic              idBranch;

  modport master (
    output idValid, idReadData1, idReadData2, idSignExt, idRs, idRt, idRd,
           idFunct, idAluOp, idAluSrc, idRegDst, idRegWrite, idMemRead,
           idMemWrite, idMemToReg, idBranch
  );

  modport slave (
    input  idValid, idReadData1, idReadData2, idSignExt, idRs, idRt, idRd,
           idFunct, idAluOp, idAluSrc, idRegDst, idRegWrite, idMemRead,
           idMemWrite, idMemToReg, idBranch
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with execute-stage operand forwarding, ALU control decode
// and load-use hazard detection, sitting directly upstream of the ALU.
module ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  ex_operand_stage_if.slave id,
  input  logic              exMemRegWrite,
  input  logic [REG_W-1:0]  exMemWriteReg,
  input  logic [DATA_W-1:0] exMemAluRes,
  input  logic              memWbRegWrite,
  input  logic [REG_W-1:0]  memWbWriteReg,
  input  logic [DATA_W-1:0] memWbWriteData,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [3:0]        aluCtr,
  output logic [DATA_W-1:0] exStoreData,
  output logic [REG_W-1:0]  exWriteReg,
  output logic              exValid,
  output logic              exRegWrite,
  output logic              exMemRead,
  output logic              exMemWrite,
  output logic              exMemToReg,
  output logic              exBranch,
  output logic              loadUseHazard
);

  logic              valid_r, alusrc_r, regdst_r;
  logic              regwrite_r, memread_r, memwrite_r, memtoreg_r, branch_r;
  logic [DATA_W-1:0] rd1_r, rd2_r, signext_r;
  logic [REG_W-1:0]  rs_r, rt_r, rd_r;
  logic [5:0]        funct_r;
  logic [1:0]        aluop_r;
  logic [DATA_W-1:0] fwd_a_s, fwd_b_s;
  logic [REG_W-1:0]  wreg_s;
  logic [3:0]        alu_ctr_s;

  // Youngest producer wins; register 0 is hardwired and never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [REG_W-1:0]  idx,
    input logic [DATA_W-1:0] regval,
    input logic              exw,
    input logic [REG_W-1:0]  exr,
    input logic [DATA_W-1:0] exv,
    input logic              mww,
    input logic [REG_W-1:0]  mwr,
    input logic [DATA_W-1:0] mwv
  );
    if (exw && (exr != {REG_W{1'b0}}) && (exr == idx)) begin
      return exv;
    end else if (mww && (mwr != {REG_W{1'b0}}) && (mwr == idx)) begin
      return mwv;
    end else begin
      return regval;
    end
  endfunction

  // ID/EX register: reset > flush > stall > load; idle ID slots carry no side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= 1'b0;
      alusrc_r   <= 1'b0;
      regdst_r   <= 1'b0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      branch_r   <= 1'b0;
      rd1_r      <= {DATA_W{1'b0}};
      rd2_r      <= {DATA_W{1'b0}};
      signext_r  <= {DATA_W{1'b0}};
      rs_r       <= {REG_W{1'b0}};
      rt_r       <= {REG_W{1'b0}};
      rd_r       <= {REG_W{1'b0}};
      funct_r    <= 6'b000000;
      aluop_r    <= 2'b00;
    end else if (flush) begin
      valid_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memread_r  <= 1'b0;
      memwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      branch_r   <= 1'b0;
    end else if (!stall) begin
      valid_r    <= id.idValid;
      alusrc_r   <= id.idAluSrc;
      regdst_r   <= id.idRegDst;
      regwrite_r <= id.idValid & id.idRegWrite;
      memread_r  <= id.idValid & id.idMemRead;
      memwrite_r <= id.idValid & id.idMemWrite;
      memtoreg_r <= id.idValid & id.idMemToReg;
      branch_r   <= id.idValid & id.idBranch;
      rd1_r      <= id.idReadData1;
      rd2_r      <= id.idReadData2;
      signext_r  <= id.idSignExt;
      rs_r       <= id.idRs;
      rt_r       <= id.idRt;
      rd_r       <= id.idRd;
      funct_r    <= id.idFunct;
      aluop_r    <= id.idAluOp;
    end
  end

  // ALU control decode from registered aluOp/funct.
  always_comb begin
    alu_ctr_s = 4'b0010;
    case (aluop_r)
      2'b00:   alu_ctr_s = 4'b0010;
      2'b01:   alu_ctr_s = 4'b0110;
      2'b11:   alu_ctr_s = 4'b1111;
      2'b10: begin
        case (funct_r)
          6'b100000, 6'b100001: alu_ctr_s = 4'b0010;
          6'b100010, 6'b100011: alu_ctr_s = 4'b0110;
          6'b100100:            alu_ctr_s = 4'b0000;
          6'b100101:            alu_ctr_s = 4'b0001;
          6'b100111:            alu_ctr_s = 4'b1100;
          6'b101011:            alu_ctr_s = 4'b0111;
          default:              alu_ctr_s = 4'b0010;
        endcase
      end
      default: alu_ctr_s = 4'b0010;
    endcase
  end

  // Operand forwarding for rs (A) and rt (B).
  always_comb begin
    fwd_a_s = fwd_sel(rs_r, rd1_r, exMemRegWrite, exMemWriteReg, exMemAluRes,
                      memWbRegWrite, memWbWriteReg, memWbWriteData);
    fwd_b_s = fwd_sel(rt_r, rd2_r, exMemRegWrite, exMemWriteReg, exMemAluRes,
                      memWbRegWrite, memWbWriteReg, memWbWriteData);
  end

  assign wreg_s        = regdst_r ? rd_r : rt_r;
  assign input1        = fwd_a_s;
  assign input2        = alusrc_r ? signext_r : fwd_b_s;
  assign aluCtr        = alu_ctr_s;
  assign exStoreData   = fwd_b_s;
  assign exWriteReg    = wreg_s;
  assign exValid       = valid_r;
  assign exRegWrite    = regwrite_r;
  assign exMemRead     = memread_r;
  assign exMemWrite    = memwrite_r;
  assign exMemToReg    = memtoreg_r;
  assign exBranch      = branch_r;
  // The load in EX cannot forward until MEM; a consumer in ID must wait one cycle.
  assign loadUseHazard = valid_r & memread_r & (wreg_s != {REG_W{1'b0}}) &
                         ((wreg_s == id.idRs) | (wreg_s == id.idRt));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: expected outputs are queued as ID values are
// driven and popped one cycle later when the captured instruction reaches the outputs.
module tb_ex_operand_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch;
  } id_t;

  // ctl = {valid, regWrite, memRead, memWrite, memToReg, branch}
  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  ctr;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic [5:0]  ctl;
  } out_t;

  typedef struct {
    string name;
    out_t  val;
    out_t  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        exMemRegWrite, memWbRegWrite;
  logic [4:0]  exMemWriteReg, memWbWriteReg;
  logic [31:0] exMemAluRes, memWbWriteData;
  logic [31:0] input1, input2, exStoreData;
  logic [3:0]  aluCtr;
  logic [4:0]  exWriteReg;
  logic        exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch;
  logic        loadUseHazard;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  out_t full_mask;

  ex_operand_stage_if #(.DATA_W(32), .REG_W(5)) idb ();

  ex_operand_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id(idb),
    .exMemRegWrite(exMemRegWrite), .exMemWriteReg(exMemWriteReg), .exMemAluRes(exMemAluRes),
    .memWbRegWrite(memWbRegWrite), .memWbWriteReg(memWbWriteReg), .memWbWriteData(memWbWriteData),
    .input1(input1), .input2(input2), .aluCtr(aluCtr), .exStoreData(exStoreData),
    .exWriteReg(exWriteReg), .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .exBranch(exBranch),
    .loadUseHazard(loadUseHazard)
  );

  always #5 clk = ~clk;

  function automatic id_t mk_id(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [5:0] fn, input logic [1:0] op,
                                input logic [6:0] ctl7);
    id_t x;
    x.valid = v; x.rd1 = r1; x.rd2 = r2; x.imm = imm;
    x.rs = rs; x.rt = rt; x.rd = rd; x.funct = fn; x.aluop = op;
    {x.alusrc, x.regdst, x.regwrite, x.memread, x.memwrite, x.memtoreg, x.branch} = ctl7;
    return x;
  endfunction

  function automatic out_t mk_out(input logic [31:0] i1, input logic [31:0] i2, input logic [3:0] c,
                                  input logic [31:0] st, input logic [4:0] w, input logic [5:0] ctl);
    out_t o;
    o.in1 = i1; o.in2 = i2; o.ctr = c; o.store = st; o.wreg = w; o.ctl = ctl;
    return o;
  endfunction

  function automatic out_t obs_now();
    return mk_out(input1, input2, aluCtr, exStoreData, exWriteReg,
                  {exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch});
  endfunction

  task automatic drive_id(input id_t x);
    idb.idValid = x.valid; idb.idReadData1 = x.rd1; idb.idReadData2 = x.rd2;
    idb.idSignExt = x.imm; idb.idRs = x.rs; idb.idRt = x.rt; idb.idRd = x.rd;
    idb.idFunct = x.funct; idb.idAluOp = x.aluop; idb.idAluSrc = x.alusrc;
    idb.idRegDst = x.regdst; idb.idRegWrite = x.regwrite; idb.idMemRead = x.memread;
    idb.idMemWrite = x.memwrite; idb.idMemToReg = x.memtoreg; idb.idBranch = x.branch;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] ev,
                         input logic mw, input logic [4:0] mr, input logic [31:0] mv);
    exMemRegWrite = ew; exMemWriteReg = er; exMemAluRes = ev;
    memWbRegWrite = mw; memWbWriteReg = mr; memWbWriteData = mv;
  endtask

  task automatic push(input string nm, input out_t v, input out_t m);
    exp_t e;
    e.name = nm; e.val = v; e.mask = m;
    sbq.push_back(e);
  endtask

  // Advances one edge and pops the entry due now; ok=0 if nothing was queued.
  task automatic tick_pop(output exp_t e, output bit ok);
    @(posedge clk);
    #1;
    ok = (sbq.size() != 0);
    if (ok) e = sbq.pop_front();
    else e.name = "scoreboard_empty";
  endtask

  task automatic test_reset();
    exp_t e; bit ok; out_t o;
    reset = 1'b1;
    drive_id(mk_id(1'b1, 32'd10, 32'd20, 32'd0, 5'd3, 5'd4, 5'd5, 6'b100010, 2'b10, 7'b0111111));
    set_fwd(1'b1, 5'd3, 32'h5555, 1'b1, 5'd4, 32'h9999);
    for (int i = 0; i < 2; i++) begin
      push($sformatf("reset_c%0d", i), mk_out(32'd0, 32'd0, 4'b0010, 32'd0, 5'd0, 6'd0), full_mask);
      tick_pop(e, ok);
      o = obs_now();
      total++;
      if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
      end
    end
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_rtype_add();
    exp_t e; bit ok; out_t o;
    reset = 1'b0;
    drive_id(mk_id(1'b1, 32'd10, 32'd20, 32'd0, 5'd3, 5'd4, 5'd5, 6'b100000, 2'b10, 7'b0110000));
    push("rtype_add", mk_out(32'd10, 32'd20, 4'b0010, 32'd20, 5'd5, 6'b110000), full_mask);
    tick_pop(e, ok);
    o = obs_now();
    total++;
    if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
      bad++;
      $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
    end
  endtask

  task automatic test_forwarding();
    exp_t e; bit ok; out_t o; id_t x; out_t w; string nm;
    for (int i = 0; i < 5; i++) begin
      x = mk_id(1'b1, 32'd1, 32'd2, 32'd0, 5'd7, 5'd7, 5'd9, 6'b100010, 2'b10, 7'b0110000);
      case (i)
        0: begin set_fwd(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 32'h99); nm = "fwd_exmem_prio";
                 w = mk_out(32'h55, 32'h55, 4'b0110, 32'h55, 5'd9, 6'b110000); end
        1: begin set_fwd(1'b0, 5'd7, 32'h55, 1'b1, 5'd7, 32'h99); nm = "fwd_memwb";
                 w = mk_out(32'h99, 32'h99, 4'b0110, 32'h99, 5'd9, 6'b110000); end
        2: begin set_fwd(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h99); nm = "fwd_r0_blocked";
                 x.rs = 5'd0; x.rt = 5'd0;
                 w = mk_out(32'd1, 32'd2, 4'b0110, 32'd2, 5'd9, 6'b110000); end
        3: begin set_fwd(1'b1, 5'd7, 32'h55, 1'b1, 5'd6, 32'h99); nm = "fwd_split";
                 x.rt = 5'd6;
                 w = mk_out(32'h55, 32'h99, 4'b0110, 32'h99, 5'd9, 6'b110000); end
        default: begin set_fwd(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 32'h99); nm = "fwd_nomatch";
                 x.rs = 5'd5; x.rt = 5'd6;
                 w = mk_out(32'd1, 32'd2, 4'b0110, 32'd2, 5'd9, 6'b110000); end
      endcase
      drive_id(x);
      push(nm, w, full_mask);
      tick_pop(e, ok);
      o = obs_now();
      total++;
      if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
      end
    end
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_alu_decode();
    exp_t e; bit ok; out_t o; out_t m;
    logic [7:0] opfn [11];
    logic [3:0] want [11];
    opfn = '{{2'b10, 6'b100001}, {2'b10, 6'b100011}, {2'b10, 6'b100100}, {2'b10, 6'b100101},
             {2'b10, 6'b100111}, {2'b10, 6'b101011}, {2'b10, 6'b000000}, {2'b00, 6'b100100},
             {2'b01, 6'b100100}, {2'b11, 6'b100101}, {2'b10, 6'b101010}};
    want = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0010, 4'b0010,
             4'b0110, 4'b1111, 4'b0010};
    m = '0; m.ctr = 4'b1111;
    for (int i = 0; i < 11; i++) begin
      drive_id(mk_id(1'b1, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd3, opfn[i][5:0], opfn[i][7:6], 7'b0110000));
      push($sformatf("alu_decode_%0d", i), mk_out(32'd0, 32'd0, want[i], 32'd0, 5'd0, 6'd0), m);
      tick_pop(e, ok);
      o = obs_now();
      total++;
      if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e; bit ok; out_t o; id_t nx; logic want_h;
    for (int k = 0; k < 3; k++) begin
      // k=0: lw r8; k=1: lw r0; k=2: lw r8 in an invalid slot
      drive_id(mk_id(k != 2, 32'd100, 32'd0, 32'd4, 5'd1, (k == 1) ? 5'd0 : 5'd8, 5'd0,
                     6'b000000, 2'b00, 7'b1011010));
      push($sformatf("lw_capture_%0d", k),
           mk_out(32'd100, 32'd4, 4'b0010, 32'd0, (k == 1) ? 5'd0 : 5'd8,
                  (k == 2) ? 6'b000000 : 6'b111010), full_mask);
      tick_pop(e, ok);
      o = obs_now();
      total++;
      if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
      end
      for (int j = 0; j < 3; j++) begin
        nx = mk_id(1'b1, 32'd0, 32'd0, 32'd0, 5'd2, 5'd3, 5'd4, 6'b100000, 2'b10, 7'b0110000);
        if (j == 0) nx.rs = (k == 1) ? 5'd0 : 5'd8;
        if (j == 1) nx.rt = (k == 1) ? 5'd0 : 5'd8;
        want_h = (k == 0) && (j != 2);
        drive_id(nx);
        #1;
        total++;
        if (loadUseHazard !== want_h) begin
          bad++;
          $display("FAIL load_use_k%0d_j%0d: got %b want %b", k, j, loadUseHazard, want_h);
        end
      end
    end
  endtask

  task automatic test_stall_flush();
    exp_t e; bit ok; out_t o; out_t m; out_t held;
    held = mk_out(32'h11, 32'h22, 4'b0001, 32'h22, 5'd3, 6'b111111);
    m = '0; m.ctl = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      stall = (i != 0);
      flush = (i == 4);
      if (i == 0)
        drive_id(mk_id(1'b1, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 6'b100101, 2'b10, 7'b0111111));
      else
        drive_id(mk_id(1'b1, 32'hA0 + i, 32'hB0 + i, 32'hC0, 5'd10 + i, 5'd20, 5'd30,
                       6'b100100, 2'b10, 7'b1011111));
      if (i == 4) push("stall_flush_bubble", mk_out(32'd0, 32'd0, 4'd0, 32'd0, 5'd0, 6'd0), m);
      else push($sformatf("stall_hold_%0d", i), held, full_mask);
      tick_pop(e, ok);
      o = obs_now();
      total++;
      if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_store_branch();
    exp_t e; bit ok; out_t o;
    set_fwd(1'b1, 5'd3, 32'h777, 1'b1, 5'd9, 32'h1234);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive_id(mk_id(1'b1, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd2, 5'd9, 5'd0,
                       6'b000000, 2'b00, 7'b1000100));
        push("sw_imm_store", mk_out(32'h1000, 32'hFFFFFFFC, 4'b0010, 32'h1234, 5'd9, 6'b100100), full_mask);
      end else begin
        drive_id(mk_id(1'b1, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd2, 5'd9, 5'd0,
                       6'b000000, 2'b11, 7'b0000001));
        push("bne_ctr", mk_out(32'h1000, 32'h1234, 4'b1111, 32'h1234, 5'd9, 6'b100001), full_mask);
      end
      tick_pop(e, ok);
      o = obs_now();
      total++;
      if (!ok || ((o & e.mask) !== (e.val & e.mask))) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, o & e.mask, e.val & e.mask);
      end
    end
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    full_mask = '1;
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(mk_id(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 7'd0));
    #2;
    test_reset();
    test_rtype_add();
    test_forwarding();
    test_alu_decode();
    test_load_use();
    test_stall_flush();
    test_store_branch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus execute-stage operand logic; sits directly upstream of the ALU.
- Captures decoded operands and control from ID and forwards results from EX/MEM and MEM/WB.
- Drives the ALU's input1, input2 and aluCtr, and detects load-use hazards for the hazard unit.
- Passes memory and writeback control to the EX/MEM register.

Parameters:
- DATA_W, 32, datapath width (ALU operand width).
- REG_W, 5, register-index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold ID/EX contents.
- flush  in  1  load a bubble into ID/EX.
- idValid  in  1  ID holds a real instruction.
- idReadData1 / idReadData2  in  DATA_W  register-file reads for rs / rt.
- idSignExt  in  DATA_W  sign-extended immediate.
- idRs / idRt / idRd  in  REG_W  register indices.
- idFunct  in  6  instruction funct field.
- idAluOp  in  2  00 add, 01 sub, 10 R-type, 11 bne.
- idAluSrc, idRegDst, idRegWrite, idMemRead, idMemWrite, idMemToReg, idBranch  in  1 each  decoded control bits.
- exMemRegWrite  in  1  EX/MEM will write a register.
- exMemWriteReg  in  REG_W  EX/MEM destination index.
- exMemAluRes  in  DATA_W  EX/MEM result.
- memWbRegWrite  in  1  MEM/WB will write a register.
- memWbWriteReg  in  REG_W  MEM/WB destination index.
- memWbWriteData  in  DATA_W  MEM/WB writeback value.
- input1 / input2  out  DATA_W  ALU operands.
- aluCtr  out  4  ALU operation code.
- exStoreData  out  DATA_W  forwarded rt value for sw.
- exWriteReg  out  REG_W  resolved destination: rd if regDst, else rt.
- exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch  out  1 each  registered control.
- loadUseHazard  out  1  ID must stall one cycle.

Behaviour:
- Register update on rising clk edge; priority is reset > flush > stall > load.
- Reset:
  - All registered fields clear to 0.
  - Combinational outputs follow from the zeroed state: input1 = input2 = 0, aluCtr = 4'b0010, exValid = 0.
- Flush: exValid and all control bits (regWrite, memRead, memWrite, memToReg, branch) clear to 0; data fields are don't-care. Flush wins over a simultaneous stall.
- Stall without flush: all registers hold their values.
- Load: every id* field is captured, and exValid <= idValid.
- When idValid = 0, the captured control bits are forced to 0.
- Latency: ID values appear on the ex* and ALU outputs one cycle after capture.
- aluCtr decode is combinational from the registered aluOp and funct:
  - aluOp 00 -> 0010; 01 -> 0110; 11 -> 1111.
  - aluOp 10 with funct 100000 or 100001 -> 0010.
  - funct 100010 or 100011 -> 0110.
  - funct 100100 -> 0000.
  - funct 100101 -> 0001.
  - funct 100111 -> 1100.
  - funct 101011 -> 0111.
  - Any other funct -> 0010.
- Forwarding (combinational), applied separately for rs (A) and rt (B):
  - EX/MEM is used if exMemRegWrite = 1, exMemWriteReg != 0, and the index matches.
  - Otherwise MEM/WB is used under the same conditions.
  - Otherwise the registered read data is used.
  - EX/MEM has priority when both stages match.
  - Register 0 is never forwarded.
- ALU operands: input1 = forwarded A. input2 = registered sign-extended immediate if aluSrc = 1, else forwarded B.
- exStoreData = forwarded B, regardless of aluSrc.
- loadUseHazard (combinational) = exValid & exMemRead & (exWriteReg != 0) & ((exWriteReg == idRs) | (exWriteReg == idRt)).
  - The hazard unit turns this into stall of IF/ID and flush of ID/EX on the same edge.
  - The block does not self-stall.

Test Plan:
- Reset held 2 cycles during a load with idValid = 1 -> all outputs 0, aluCtr = 0010, exValid = 0. Release reset -> next edge captures the ID values.
- R-type add: rs = 3 (10), rt = 4 (20), funct 100000, regDst = 1, rd = 5 -> next cycle input1 = 10, input2 = 20, aluCtr = 0010, exWriteReg = 5.
- Double forward: rs = rt = 7; EX/MEM writes r7 = 0x55; MEM/WB writes r7 = 0x99 -> input1 = input2 = 0x55.
  - Repeat with exMemRegWrite = 0 -> both operands 0x99.
  - Repeat with both stages targeting r0 -> registered read data used.
- lw r8 captured with memRead = 1; next ID instruction uses rs = 8 -> loadUseHazard = 1.
  - Same with ID rt = 8 -> loadUseHazard = 1.
  - Destination r0, or exValid = 0 -> loadUseHazard = 0.
- Stall held 3 cycles while ID inputs change -> outputs frozen. Assert stall and flush together -> bubble loaded: exValid = 0, exRegWrite = 0, exMemWrite = 0.
- sw with aluSrc = 1, imm = 0xFFFFFFFC, rt forwarded from MEM/WB = 0x1234 -> input2 = 0xFFFFFFFC, exStoreData = 0x1234, aluCtr = 0010. With aluOp 11 -> aluCtr = 1111.
